cpu_ad48_run_ctrl: RTL and testbench

Run controller for the cpu_ad48 core. It drives the core's reset and clock-enable from start, stop and step pulses, and holds reset for a programmed number of cycles before releasing the core. It detects halt, enforces an optional cycle-budget timeout, and counts enabled cycles and retired instructions. It sits between the bench/debug host and the core, replacing hand-sequenced reset release and `wait(halt)` loops.

---
 rtl/cpu_ad48_run_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cpu_ad48_run_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ad48_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ad48_run_ctrl
//
// Run controller for the cpu_ad48 core. It turns start/stop/step pulses from
// the host into the core's reset and clock-enable. After a start it holds the
// core in reset for HOLD_CYCLES cycles and then releases it. It watches the
// core's halt flag and an optional enabled-cycle budget. It also counts
// enabled cycles and retired instructions.
//
// Parameters
//   HOLD_CYCLES  cycles core reset stays asserted after a start (>= 1)
//   CNT_W        width of the cycle and retire counters
//   TIMEOUT      enabled-cycle budget per run, 0 disables the budget
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   start_i        pulse: IDLE/DONE -> reset core and run; PAUSE -> resume
//   stop_i         pulse: RUN -> PAUSE
//   step_i         pulse: PAUSE -> one enabled cycle
//   core_halt_i    core halt level (sticky in the core)
//   core_retire_i  one-cycle pulse per retired instruction
//   core_rst_o     active-high reset to the core
//   core_en_o      core clock enable / stall_n
//   busy_o         state is HOLD, RUN, STEP or PAUSE
//   done_o         state is DONE
//   timeout_o      the last run ended because the budget was used up
//   cycle_cnt_o    enabled-cycle count (saturating)
//   retire_cnt_o   retired-instruction count (saturating)
//   state_o        IDLE=0 HOLD=1 RUN=2 STEP=3 PAUSE=4 DONE=5
// ---------------------------------------------------------------------------
module cpu_ad48_run_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             step_i,
    input  logic             core_halt_i,
    input  logic             core_retire_i,
    output logic             core_rst_o,
    output logic             core_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [2:0]       state_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HOLD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // The hold counter is loaded with HOLD_CYCLES-1 and counts down to zero.
    // This keeps HOLD visible for exactly HOLD_CYCLES cycles.
    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // A budget larger than the counter can ever show would never be reached.
    // Such a budget is treated as disabled instead of being truncated.
    localparam bit TO_FITS   = (CNT_W >= 32) ? 1'b1 : ((TIMEOUT >> CNT_W) == 0);
    localparam bit BUDGET_ON = (TIMEOUT != 0) && TO_FITS;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [2:0]        state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [CNT_W-1:0]  cycle_q,   cycle_d;
    logic [CNT_W-1:0]  retire_q,  retire_d;
    logic              timeout_q, timeout_d;

    logic              en;
    logic [CNT_W-1:0]  cycle_inc;
    logic [CNT_W-1:0]  retire_inc;
    logic              budget_hit;

    // The core enable is decoded from the state register. Everything that
    // "counts this edge" therefore refers to the state the core was actually in.
    assign en = (state_q == ST_RUN) || (state_q == ST_STEP);

    assign cycle_inc  = (cycle_q  == CNT_MAX) ? cycle_q  : cycle_q  + 1'b1;
    assign retire_inc = (retire_q == CNT_MAX) ? retire_q : retire_q + 1'b1;

    // The budget is compared against the count this edge produces. The core
    // therefore gets exactly TIMEOUT enabled cycles.
    assign budget_hit = BUDGET_ON && en && (cycle_inc == TIMEOUT_C);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        timeout_d = timeout_q;

        if (en) begin
            cycle_d = cycle_inc;
            if (core_retire_i) begin
                retire_d = retire_inc;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_HOLD;
                    hold_d    = HOLD_LOAD;
                    cycle_d   = '0;
                    retire_d  = '0;
                    timeout_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            ST_RUN: begin
                // A halt wins over the budget. If both happen on the same
                // edge, the run ended normally.
                if (core_halt_i) begin
                    state_d = ST_DONE;
                end else if (budget_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else if (stop_i) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_STEP: begin
                if (core_halt_i) begin
                    state_d = ST_DONE;
                end else if (budget_hit) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                // If start and step arrive together, start wins.
                if (core_halt_i) begin
                    state_d = ST_DONE;
                end else if (start_i) begin
                    state_d = ST_RUN;
                end else if (step_i) begin
                    state_d = ST_STEP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            cycle_q   <= '0;
            retire_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cycle_q   <= cycle_d;
            retire_q  <= retire_d;
            timeout_q <= timeout_d;
        end
    end

    // Because rst clears state_q asynchronously, core_rst_o also rises
    // without waiting for a clock edge.
    assign core_rst_o   = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign core_en_o    = en;
    assign busy_o       = (state_q == ST_HOLD) || (state_q == ST_RUN) ||
                          (state_q == ST_STEP) || (state_q == ST_PAUSE);
    assign done_o       = (state_q == ST_DONE);
    assign timeout_o    = timeout_q;
    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_cpu_ad48_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ad48_run_ctrl
//
// Directed bench for cpu_ad48_run_ctrl. It uses three instances:
//   dut0: defaults (HOLD_CYCLES=4, CNT_W=32, no budget)
//   dut1: TIMEOUT=20
//   dut2: CNT_W=4, which exercises counter saturation
// Inputs are driven 1ns after a rising edge. Outputs are sampled at the same
// point.
// ---------------------------------------------------------------------------
module tb_cpu_ad48_run_ctrl;

    logic clk     = 1'b0;
    logic clk_run = 1'b1;
    logic rst;

    logic [2:0] start_v, stop_v, step_v, halt_v, ret_v;
    logic [2:0] c_rst, c_en, busy, done, tout;
    logic [2:0] st0, st1, st2;
    logic [31:0] cyc0, ret0, cyc1, ret1;
    logic [3:0]  cyc2, ret2;

    int n_chk  = 0;
    int n_fail = 0;

    // The clock can be frozen low to observe the asynchronous reset.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    cpu_ad48_run_ctrl dut0 (
        .clk(clk), .rst(rst),
        .start_i(start_v[0]), .stop_i(stop_v[0]), .step_i(step_v[0]),
        .core_halt_i(halt_v[0]), .core_retire_i(ret_v[0]),
        .core_rst_o(c_rst[0]), .core_en_o(c_en[0]), .busy_o(busy[0]),
        .done_o(done[0]), .timeout_o(tout[0]),
        .cycle_cnt_o(cyc0), .retire_cnt_o(ret0), .state_o(st0)
    );

    cpu_ad48_run_ctrl #(.HOLD_CYCLES(4), .CNT_W(32), .TIMEOUT(20)) dut1 (
        .clk(clk), .rst(rst),
        .start_i(start_v[1]), .stop_i(stop_v[1]), .step_i(step_v[1]),
        .core_halt_i(halt_v[1]), .core_retire_i(ret_v[1]),
        .core_rst_o(c_rst[1]), .core_en_o(c_en[1]), .busy_o(busy[1]),
        .done_o(done[1]), .timeout_o(tout[1]),
        .cycle_cnt_o(cyc1), .retire_cnt_o(ret1), .state_o(st1)
    );

    cpu_ad48_run_ctrl #(.HOLD_CYCLES(4), .CNT_W(4), .TIMEOUT(0)) dut2 (
        .clk(clk), .rst(rst),
        .start_i(start_v[2]), .stop_i(stop_v[2]), .step_i(step_v[2]),
        .core_halt_i(halt_v[2]), .core_retire_i(ret_v[2]),
        .core_rst_o(c_rst[2]), .core_en_o(c_en[2]), .busy_o(busy[2]),
        .done_o(done[2]), .timeout_o(tout[2]),
        .cycle_cnt_o(cyc2), .retire_cnt_o(ret2), .state_o(st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_chk++; if (st0 !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st0); end
        n_chk++; if (c_rst !== 3'b111) begin n_fail++; $display("FAIL reset_core_rst: got %b want 111", c_rst); end
        n_chk++; if (c_en !== 3'b000) begin n_fail++; $display("FAIL reset_core_en: got %b want 000", c_en); end
        n_chk++; if (busy !== 3'b000 || done !== 3'b000 || tout !== 3'b000) begin n_fail++; $display("FAIL reset_flags: busy %b done %b tout %b want 000", busy, done, tout); end
        n_chk++; if (cyc0 !== 32'd0 || ret0 !== 32'd0 || cyc2 !== 4'd0) begin n_fail++; $display("FAIL reset_counters: cyc %0d ret %0d cyc2 %0d want 0", cyc0, ret0, cyc2); end
        // Stop and step are ignored in IDLE.
        stop_v[0] = 1'b1; step_v[0] = 1'b1;
        tick();
        stop_v[0] = 1'b0; step_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd0) begin n_fail++; $display("FAIL idle_ignores_stop_step: got %0d want 0", st0); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd1 || c_rst[0] !== 1'b1) begin n_fail++; $display("FAIL basic_hold_entry: state %0d rst %b want 1/1", st0, c_rst[0]); end
        for (int i = 1; i < 4; i++) begin
            tick();
            n_chk++; if (st0 !== 3'd1 || c_rst[0] !== 1'b1 || c_en[0] !== 1'b0) begin n_fail++; $display("FAIL basic_hold_%0d: state %0d rst %b en %b want 1/1/0", i, st0, c_rst[0], c_en[0]); end
        end
        tick();
        n_chk++; if (st0 !== 3'd2 || c_rst[0] !== 1'b0 || c_en[0] !== 1'b1 || busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_release: state %0d rst %b en %b busy %b want 2/0/1/1", st0, c_rst[0], c_en[0], busy[0]); end
        repeat (9) tick();
        n_chk++; if (cyc0 !== 32'd9 || st0 !== 3'd2) begin n_fail++; $display("FAIL basic_run9: cyc %0d state %0d want 9/2", cyc0, st0); end
        halt_v[0] = 1'b1;
        tick();
        halt_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd5 || done[0] !== 1'b1 || busy[0] !== 1'b0 || c_en[0] !== 1'b0) begin n_fail++; $display("FAIL basic_halt: state %0d done %b busy %b en %b want 5/1/0/0", st0, done[0], busy[0], c_en[0]); end
        n_chk++; if (cyc0 !== 32'd10 || tout[0] !== 1'b0) begin n_fail++; $display("FAIL basic_count: cyc %0d tout %b want 10/0", cyc0, tout[0]); end
        tick();
        n_chk++; if (st0 !== 3'd5 || cyc0 !== 32'd10) begin n_fail++; $display("FAIL basic_done_hold: state %0d cyc %0d want 5/10", st0, cyc0); end
        $display("test_basic done");
    endtask

    task automatic test_step();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd1 || cyc0 !== 32'd0 || ret0 !== 32'd0) begin n_fail++; $display("FAIL step_restart_clear: state %0d cyc %0d ret %0d want 1/0/0", st0, cyc0, ret0); end
        repeat (4) tick();
        n_chk++; if (st0 !== 3'd2) begin n_fail++; $display("FAIL step_run: state %0d want 2", st0); end
        repeat (4) tick();
        // Start and stop arrive together in RUN, so stop wins.
        start_v[0] = 1'b1; stop_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; stop_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd4 || c_en[0] !== 1'b0 || c_rst[0] !== 1'b0 || cyc0 !== 32'd5) begin n_fail++; $display("FAIL step_stop: state %0d en %b rst %b cyc %0d want 4/0/0/5", st0, c_en[0], c_rst[0], cyc0); end
        tick();
        n_chk++; if (cyc0 !== 32'd5 || st0 !== 3'd4) begin n_fail++; $display("FAIL step_pause_idle: cyc %0d state %0d want 5/4", cyc0, st0); end
        for (int k = 0; k < 3; k++) begin
            step_v[0] = 1'b1;
            tick();
            step_v[0] = 1'b0;
            n_chk++; if (st0 !== 3'd3 || c_en[0] !== 1'b1) begin n_fail++; $display("FAIL step_%0d_on: state %0d en %b want 3/1", k, st0, c_en[0]); end
            tick();
            n_chk++; if (st0 !== 3'd4 || c_en[0] !== 1'b0 || cyc0 !== 32'(6 + k)) begin n_fail++; $display("FAIL step_%0d_off: state %0d en %b cyc %0d want 4/0/%0d", k, st0, c_en[0], cyc0, 6 + k); end
        end
        // Start and step arrive together in PAUSE, so start wins.
        start_v[0] = 1'b1; step_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; step_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd2 || cyc0 !== 32'd8) begin n_fail++; $display("FAIL step_resume: state %0d cyc %0d want 2/8", st0, cyc0); end
        tick();
        halt_v[0] = 1'b1;
        tick();
        halt_v[0] = 1'b0;
        n_chk++; if (st0 !== 3'd5 || cyc0 !== 32'd10) begin n_fail++; $display("FAIL step_total: state %0d cyc %0d want 5/10", st0, cyc0); end
        $display("test_step done");
    endtask

    task automatic test_retire();
        logic [9:0] pat;
        pat = 10'b0110111011;   // 4 ones in bits 0..4, 3 ones in bits 5..9
        ret_v[0] = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        n_chk++; if (ret0 !== 32'd0 || st0 !== 3'd2) begin n_fail++; $display("FAIL retire_hold_ignored: ret %0d state %0d want 0/2", ret0, st0); end
        for (int e = 0; e < 5; e++) begin
            ret_v[0] = pat[e];
            stop_v[0] = (e == 4);
            tick();
        end
        stop_v[0] = 1'b0;
        n_chk++; if (ret0 !== 32'd4 || st0 !== 3'd4) begin n_fail++; $display("FAIL retire_first_half: ret %0d state %0d want 4/4", ret0, st0); end
        ret_v[0] = 1'b1;
        repeat (2) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n_chk++; if (ret0 !== 32'd4 || st0 !== 3'd2) begin n_fail++; $display("FAIL retire_pause_ignored: ret %0d state %0d want 4/2", ret0, st0); end
        for (int e = 5; e < 10; e++) begin
            ret_v[0] = pat[e];
            halt_v[0] = (e == 9);
            tick();
        end
        halt_v[0] = 1'b0;
        ret_v[0] = 1'b0;
        n_chk++; if (ret0 !== 32'd7 || cyc0 !== 32'd10 || st0 !== 3'd5) begin n_fail++; $display("FAIL retire_total: ret %0d cyc %0d state %0d want 7/10/5", ret0, cyc0, st0); end
        $display("test_retire done");
    endtask

    task automatic test_async_rst();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (4) tick();
        repeat (3) tick();
        n_chk++; if (st0 !== 3'd2 || cyc0 !== 32'd3) begin n_fail++; $display("FAIL arst_pre_run: state %0d cyc %0d want 2/3", st0, cyc0); end
        @(negedge clk);
        #1;
        clk_run = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        n_chk++; if (st0 !== 3'd0 || c_rst[0] !== 1'b1 || c_en[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL arst_state: state %0d rst %b en %b busy %b want 0/1/0/0", st0, c_rst[0], c_en[0], busy[0]); end
        n_chk++; if (cyc0 !== 32'd0 || ret0 !== 32'd0) begin n_fail++; $display("FAIL arst_counters: cyc %0d ret %0d want 0/0", cyc0, ret0); end
        #5;
        rst = 1'b0;
        #5;
        clk_run = 1'b1;
        tick();
        $display("test_async_rst done");
    endtask

    task automatic test_timeout();
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        repeat (4) tick();
        repeat (19) tick();
        n_chk++; if (st1 !== 3'd2 || cyc1 !== 32'd19) begin n_fail++; $display("FAIL timeout_pre: state %0d cyc %0d want 2/19", st1, cyc1); end
        tick();
        n_chk++; if (st1 !== 3'd5 || tout[1] !== 1'b1 || cyc1 !== 32'd20 || c_en[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_hit: state %0d tout %b cyc %0d en %b want 5/1/20/0", st1, tout[1], cyc1, c_en[1]); end
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        n_chk++; if (tout[1] !== 1'b0 || cyc1 !== 32'd0 || st1 !== 3'd1) begin n_fail++; $display("FAIL timeout_restart: tout %b cyc %0d state %0d want 0/0/1", tout[1], cyc1, st1); end
        repeat (4) tick();
        repeat (19) tick();
        halt_v[1] = 1'b1;
        tick();
        halt_v[1] = 1'b0;
        n_chk++; if (st1 !== 3'd5 || tout[1] !== 1'b0 || cyc1 !== 32'd20) begin n_fail++; $display("FAIL timeout_halt_same_edge: state %0d tout %b cyc %0d want 5/0/20", st1, tout[1], cyc1); end
        $display("test_timeout done");
    endtask

    task automatic test_saturate();
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        repeat (4) tick();
        repeat (19) tick();
        n_chk++; if (cyc2 !== 4'd15 || st2 !== 3'd2) begin n_fail++; $display("FAIL sat_run: cyc %0d state %0d want 15/2", cyc2, st2); end
        halt_v[2] = 1'b1;
        tick();
        halt_v[2] = 1'b0;
        n_chk++; if (cyc2 !== 4'd15 || st2 !== 3'd5 || done[2] !== 1'b1) begin n_fail++; $display("FAIL sat_halt: cyc %0d state %0d done %b want 15/5/1", cyc2, st2, done[2]); end
        $display("test_saturate done");
    endtask

    initial begin
        start_v = '0; stop_v = '0; step_v = '0; halt_v = '0; ret_v = '0;
        rst = 1'b1;
        #3;
        test_reset_async_only: begin end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_step();
        test_retire();
        test_async_rst();
        test_timeout();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
